sar_control: RTL and testbench

Successive-approximation controller that sits directly upstream of the comparator/latch stage of the 7-bit ADC. On each conversion it drives trial codes onto the comparator's reference input (`analogcompare`), samples the registered comparator result (`trustbit`), and resolves one bit per step, MSB first. It presents the final code on `dout` with a one-cycle `done` pulse.

---
 rtl/sar_control.sv | 87 ++++++++
 tb/tb_sar_control.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sar_control.sv
// Successive-approximation controller for the 7-bit ADC comparator stage.
// Resolves one bit per step, MSB first, and presents the result with a done pulse.
module sar_control #(
  parameter int unsigned WIDTH  = 7,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             trustbit,
  output logic [WIDTH-1:0] analogcompare,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CntW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {StIdle, StTrial, StWait, StDecide} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  code_q;
  logic [IdxW-1:0]   idx_q;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  trial;

  always_comb begin
    trial = code_q | (WIDTH'(1) << idx_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      code_q        <= '0;
      idx_q         <= IdxW'(WIDTH - 1);
      cnt_q         <= '0;
      analogcompare <= '0;
      dout          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            code_q  <= '0;
            idx_q   <= IdxW'(WIDTH - 1);
            busy    <= 1'b1;
            state_q <= StTrial;
          end
        end
        StTrial: begin
          // Offset by one so a comparator ">=" test keeps the bit at equality.
          analogcompare <= trial - WIDTH'(1);
          cnt_q         <= CntW'(SETTLE);
          state_q       <= StWait;
        end
        StWait: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q <= StDecide;
          end
        end
        StDecide: begin
          if (idx_q != '0) begin
            if (!trustbit) begin
              code_q <= trial;
            end
            idx_q   <= idx_q - IdxW'(1);
            state_q <= StTrial;
          end else begin
            dout    <= trustbit ? code_q : trial;
            if (!trustbit) begin
              code_q <= trial;
            end
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_control.sv
// Bench for sar_control: comparator model on each DUT, binary-search reference for
// the trial sequence, directed boundary cases plus random input levels.
module tb_sar_control;

  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start1 = 1'b0;
  logic         start3 = 1'b0;
  logic         two_stage = 1'b0;
  logic         trust1 = 1'b0;
  logic         trust3 = 1'b0;
  logic         stg = 1'b0;
  logic [W-1:0] ac1, dout1, ac3, dout3;
  logic         busy1, done1, busy3, done3;
  int           a = 0;
  int           exp_dout = 0;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           exp_q[$];
  int           got_q[$];
  int           s77[7] = '{63, 95, 79, 71, 75, 77, 76};

  sar_control #(.WIDTH(W), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .trustbit(trust1),
    .analogcompare(ac1), .dout(dout1), .busy(busy1), .done(done1)
  );

  sar_control #(.WIDTH(W), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .trustbit(trust3),
    .analogcompare(ac3), .dout(dout3), .busy(busy3), .done(done3)
  );

  always #5 clk = ~clk;

  // Comparator latch; the two-stage path models a comparator that latches one edge late.
  always @(posedge clk) begin
    stg    <= (int'(ac1) >= a);
    trust1 <= two_stage ? stg : (int'(ac1) >= a);
    trust3 <= (int'(ac3) >= a);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Binary search: expected trial codes (minus one) as presented to the comparator.
  function automatic void build(input int av);
    int code, t;
    exp_q.delete();
    code = 0;
    for (int b = W - 1; b >= 0; b--) begin
      t = code | (1 << b);
      exp_q.push_back(t - 1);
      if (t <= av) code = t;
    end
  endfunction

  task automatic conv1(input int av, input int ign_a, input int ign_b, input string tag);
    int cyc, last, mid_err, seq_err;
    bit seen;
    a = av;
    build(av);
    got_q.delete();
    last = int'(ac1);
    mid_err = 0;
    seen = 1'b0;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (cyc = 1; cyc <= 200; cyc++) begin
      if (cyc == ign_a || cyc == ign_b) start1 = 1'b1;
      step();
      start1 = 1'b0;
      if (int'(ac1) != last) begin
        got_q.push_back(int'(ac1));
        last = int'(ac1);
      end
      if (done1 === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy1 !== 1'b1 || int'(dout1) != exp_dout) mid_err++;
    end
    chk({tag, " busy/dout hold"}, mid_err, 0);
    chk({tag, " done latency"}, cyc, W * 3);
    chk({tag, " dout"}, dout1, av);
    chk({tag, " busy at done"}, busy1, 0);
    seq_err = 0;
    if (got_q.size() != exp_q.size()) seq_err = 100;
    else foreach (exp_q[i]) if (got_q[i] != exp_q[i]) seq_err++;
    chk({tag, " trial sequence"}, seq_err, 0);
    if (seen) exp_dout = av;
  endtask

  initial begin
    int cyc;
    step();
    step();
    chk("reset analogcompare", ac1, 0);
    chk("reset dout", dout1, 0);
    chk("reset busy", busy1, 0);
    chk("reset done", done1, 0);
    rst = 1'b0;
    step();

    conv1(77, 0, 0, "a77");
    foreach (s77[i]) chk("a77 spec sequence", (i < got_q.size()) ? got_q[i] : -1, s77[i]);
    step();
    chk("done one cycle", done1, 0);

    conv1(0, 0, 0, "a0");
    conv1(127, 0, 0, "a127");
    conv1(40, 5, 12, "ignored starts");
    conv1(90, 0, 0, "back to back");

    repeat (6) begin
      repeat ($urandom_range(0, 3)) step();
      conv1(int'($urandom_range(0, 127)), 0, 0, "random");
    end

    // Abort mid-conversion after a previous result of 77.
    conv1(77, 0, 0, "pre reset");
    a = 55;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    start1 = 1'b1;
    step();
    chk("abort analogcompare", ac1, 0);
    chk("abort dout", dout1, 0);
    chk("abort busy", busy1, 0);
    chk("abort done", done1, 0);
    rst = 1'b0;
    start1 = 1'b0;
    exp_dout = 0;
    step();
    chk("start with rst ignored", busy1, 0);
    conv1(55, 0, 0, "after abort");

    // SETTLE=3 instance.
    a = 100;
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    for (cyc = 1; cyc <= 200; cyc++) begin
      step();
      if (done3 === 1'b1) break;
    end
    chk("settle3 latency", cyc, 35);
    chk("settle3 dout", dout3, 100);

    // Late comparator with SETTLE=1 must corrupt the code.
    rst = 1'b1;
    step();
    rst = 1'b0;
    two_stage = 1'b1;
    a = 77;
    step();
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (cyc = 1; cyc <= 200; cyc++) begin
      step();
      if (done1 === 1'b1) break;
    end
    chk("late cmp latency", cyc, 21);
    n_cmp++;
    assert (dout1 !== 7'd77) else begin
      n_bad++;
      $error("FAIL late cmp dout: observed %0d expected a value other than 77", dout1);
    end
    two_stage = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
